// File: rtl/subblock_collector_pkg.sv
// Shared definitions for the sub-block result collector: default sizes,
// width helper and the FIFO entry layout (source index above payload).
package subblock_collector_pkg;

  localparam int unsigned DEF_NUM_CHILDREN = 5;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Entry width for a given source/payload split.
  function automatic int unsigned entry_w(input int unsigned src_w, input int unsigned data_w);
    return src_w + data_w;
  endfunction

  localparam int unsigned DEF_SRC_W = clog2_min1(DEF_NUM_CHILDREN);

  // Entry layout at default sizes; the top uses the same order {src, data}.
  typedef struct packed {
    logic [DEF_SRC_W-1:0]  src;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/subblock_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module subblock_rr_arbiter
  import subblock_collector_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = DEF_NUM_CHILDREN,
  localparam int unsigned SRC_W = clog2_min1(NUM_CHILDREN)
) (
  input  logic [NUM_CHILDREN-1:0] i_req,
  input  logic [SRC_W-1:0]        i_ptr,
  output logic [NUM_CHILDREN-1:0] o_grant,
  output logic [SRC_W-1:0]        o_grant_idx,
  output logic                    o_any_grant
);

  int unsigned w_idx;

  // Scan offsets 0..N-1 from ptr; the first live request wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NUM_CHILDREN; k++) begin
      w_idx = (32'(i_ptr) + k) % NUM_CHILDREN;
      for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
        if (!o_any_grant && (w_idx == i) && i_req[i]) begin
          o_grant[i]  = 1'b1;
          o_grant_idx = SRC_W'(i);
          o_any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/subblock_result_collector.sv
// Fan-in collector: round-robin accepts child results into a small tagged
// FIFO and presents them upward as one valid/ready stream.
// Optional: define SUBBLOCK_COLLECTOR_STATS_EN to add the accept_cnt port.
module subblock_result_collector
  import subblock_collector_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = DEF_NUM_CHILDREN,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  localparam int unsigned SRC_W = clog2_min1(NUM_CHILDREN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src,
  input  logic                           out_ready
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
  ,
  output logic [15:0]                    accept_cnt
`endif
);

  localparam int unsigned PTR_W = clog2_min1(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = entry_w(SRC_W, DATA_W);

  logic [ENT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [SRC_W-1:0]        r_arb_ptr;

  logic [NUM_CHILDREN-1:0] w_grant;
  logic [SRC_W-1:0]        w_grant_idx;
  logic                    w_any_grant;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic [DATA_W-1:0]       w_sel_data;
  logic [ENT_W-1:0]        w_head;

  subblock_rr_arbiter #(
    .NUM_CHILDREN (NUM_CHILDREN)
  ) u_arb (
    .i_req       (child_valid),
    .i_ptr       (r_arb_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign child_ready = (rst || w_full) ? '0 : w_grant;
  assign w_push      = w_any_grant && !w_full && !rst;
  assign w_pop       = out_valid && out_ready;

  // Payload mux for the granted child.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
      if (w_grant[i]) w_sel_data = child_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_src   = w_head[ENT_W-1 -: SRC_W];
  assign out_data  = w_head[DATA_W-1:0];

  // FIFO storage, pointers, occupancy and arbiter pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned e = 0; e < FIFO_DEPTH; e++) r_mem[e] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_arb_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_grant_idx, w_sel_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_arb_ptr       <= (w_grant_idx == SRC_W'(NUM_CHILDREN - 1)) ? '0
                                                                     : w_grant_idx + SRC_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SUBBLOCK_COLLECTOR_STATS_EN
  logic [15:0] r_accept_cnt;

  // Wrapping count of child accepts.
  always_ff @(posedge clk) begin
    if (rst)         r_accept_cnt <= '0;
    else if (w_push) r_accept_cnt <= r_accept_cnt + 16'd1;
  end

  assign accept_cnt = r_accept_cnt;
`endif

endmodule

// File: tb/tb_subblock_result_collector.sv
// Directed bench for subblock_result_collector with a queue scoreboard.
module tb_subblock_result_collector;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      child_valid;
  logic [N*DW-1:0]   child_data;
  logic [N-1:0]      child_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              out_ready;
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
  logic [15:0]       accept_cnt;
`endif

  subblock_result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready)
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
    ,
    .accept_cnt  (accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  int               errors = 0;
  int               checks = 0;
  logic [SW+DW-1:0] exp_q[$];
  int               rem[N];
  logic [N-1:0]     acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW+DW-1:0] ent(input int s, input int d);
    return {SW'(s), DW'(d)};
  endfunction

  // Child i offers payload d for n accepts, then drops valid.
  task automatic send(input int i, input logic [DW-1:0] d, input int n);
    rem[i]                 = n;
    child_data[i*DW +: DW] = d;
    child_valid[i]         = 1'b1;
  endtask

  // Child model: drop valid once its pending count is exhausted.
  always begin
    @(negedge clk);
    acc = rst ? '0 : (child_valid & child_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) rem[i]--;
      if (rem[i] == 0) child_valid[i] = 1'b0;
    end
  end

  // Scoreboard monitor: compare every upward transfer with the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got src=%0d data=0x%0h expected none", out_src, out_data);
      end else begin
        logic [SW+DW-1:0] e;
        e = exp_q.pop_front();
        check("out_src", 32'(out_src), 32'(e[DW +: SW]));
        check("out_data", 32'(out_data), 32'(e[DW-1:0]));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Pop until the scoreboard is empty, bounded.
  task automatic drain();
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    @(posedge clk); #2;
    out_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rr_exp [6];
    logic [N-1:0] full_exp [6];
    rr_exp   = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    full_exp = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h00, 5'h00};
    for (int i = 0; i < N; i++) rem[i] = 0;
    rst = 1'b1; out_ready = 1'b0; child_valid = '0; child_data = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #2 child_valid = '1;
    @(negedge clk);
    check("rst_ready", 32'(child_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);
    check("idle_out_src", 32'(out_src), 32'd0);
    check("idle_ready", 32'(child_ready), 32'd0);
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
    check("idle_accept_cnt", 32'(accept_cnt), 32'd0);
`endif
    repeat (3) @(negedge clk);
    check("idle_hold_valid", 32'(out_valid), 32'd0);
    check("idle_hold_ready", 32'(child_ready), 32'd0);

    // Single child 2
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(2, 16'h00A5, 1);
    exp_q.push_back(ent(2, 16'h00A5));
    @(negedge clk);
    check("single_ready", 32'(child_ready), 32'h04);
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h00A5);
    check("single_src", 32'(out_src), 32'd2);
    drain();

    // Round-robin fairness from a fresh pointer
    do_reset();
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(i, 16'(16'h10 + i), (i == 0) ? 2 : 1);
    for (int k = 0; k < 6; k++) exp_q.push_back(ent(k % N, 16'h10 + (k % N)));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(child_ready), 32'(rr_exp[k]));
    end
    drain();
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
    check("rr_accept_cnt", 32'(accept_cnt), 32'd6);
`endif

    // Full FIFO and backpressure
    do_reset();
    @(posedge clk); #2;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(i, 16'(16'h20 + i), 1);
    for (int i = 0; i < N; i++) exp_q.push_back(ent(i, 16'h20 + i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("full_grant", 32'(child_ready), 32'(full_exp[k]));
    end
    check("full_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_no_bypass", 32'(child_ready), 32'd0);
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    check("full_ready_back", 32'(child_ready), 32'h10);
    drain();

    // Simultaneous push and pop at two entries
    do_reset();
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(0, 16'h0030, 1);
    send(1, 16'h0031, 1);
    exp_q.push_back(ent(0, 16'h30));
    exp_q.push_back(ent(1, 16'h31));
    @(negedge clk);
    check("pp_grant0", 32'(child_ready), 32'h01);
    @(negedge clk);
    check("pp_grant1", 32'(child_ready), 32'h02);
    @(posedge clk); #2;
    send(2, 16'h0032, 1);
    exp_q.push_back(ent(2, 16'h32));
    out_ready = 1'b1;
    @(negedge clk);
    check("pp_ready", 32'(child_ready), 32'h04);
    check("pp_head0", 32'(out_data), 32'h30);
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_head1_data", 32'(out_data), 32'h31);
    check("pp_head1_src", 32'(out_src), 32'd1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_tail_valid", 32'(out_valid), 32'd1);
    check("pp_tail_data", 32'(out_data), 32'h32);
    check("pp_tail_src", 32'(out_src), 32'd2);
    drain();

    // Reset with three buffered entries (arbiter pointer sits at 3)
    @(posedge clk); #2;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 16'(16'h40 + i), 1);
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(i, 16'h40 + i));
    repeat (4) @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_src", 32'(out_src), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    send(1, 16'h0051, 1);
    send(4, 16'h0054, 1);
    exp_q.push_back(ent(1, 16'h51));
    exp_q.push_back(ent(4, 16'h54));
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    check("rst_ptr_grant", 32'(child_ready), 32'h02);
    drain();
`ifdef SUBBLOCK_COLLECTOR_STATS_EN
    check("post_rst_accept_cnt", 32'(accept_cnt), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
